alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 32-bit combinational ALU.
- Keeps opcodes 0-4 (ADD, OR, AND, SUB, SLT) and adds logical shifts and an iterative multiply.
- Registers every result together with its flags; corrects SLT to a true signed compare; reports signed overflow and carry separately.
- Sits between the operand/decode logic (upstream valid/ready) and writeback (downstream valid/ready).

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4.
- MUL_EN, 1, 1 = opcode 7 is MUL; 0 = opcode 7 completes single-cycle with f=0, illegal=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B; for shifts only y[$clog2(WIDTH)-1:0] is used.
- opcode  in  3  0 ADD, 1 OR, 2 AND, 3 SUB, 4 SLT, 5 SLL, 6 SRL, 7 MUL.
- out_valid  out  1  result registers valid.
- out_ready  in  1  downstream takes the result.
- f  out  WIDTH  result.
- cout  out  1  carry out.
- overflow  out  1  overflow flag.
- zero  out  1  f == 0.
- illegal  out  1  opcode 7 with MUL_EN=0.

Behaviour:
- Reset: state=IDLE; out_valid, f, cout, overflow, illegal = 0; zero = 1; in_ready = 1 in the cycle after reset deasserts. Reset mid-MUL abandons the operation with no output.
- Accept: occurs at a rising edge where in_valid && in_ready. x, y and opcode are captured at that edge; later changes are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Latency, ops 0-6 (and 7 with MUL_EN=0): result and flags registered at the accept edge; out_valid=1 in the following cycle (latency 1).
- Latency, MUL: state goes IDLE->BUSY at accept; a counter runs WIDTH shift-add steps; the result is registered at the WIDTH-th edge after accept, then BUSY->IDLE and out_valid=1. in_ready=0 throughout BUSY.
- Output hold: while out_valid && !out_ready, f and all flags hold stable.
- out_valid clears on an edge with out_ready=1 unless a new single-cycle op is accepted on that same edge; in that case out_valid stays 1 and the new result replaces the old.
- ADD: f = x+y mod 2^WIDTH; cout = carry out of MSB; overflow = signed overflow (operand signs equal, result sign differs).
- SUB: f = x + ~y + 1; cout = carry out (1 = no borrow); overflow = signed overflow.
- SLT: f = {0..., (x <s y)}, computed as sign(x-y) XOR overflow(x-y); cout = overflow = 0.
- OR / AND: bitwise; cout = overflow = 0.
- SLL / SRL: logical shift by y[$clog2(WIDTH)-1:0], zero fill; upper y bits ignored; cout = overflow = 0.
- MUL: unsigned; f = low WIDTH bits of the 2*WIDTH product; overflow = 1 iff high half != 0; cout = 0.
- zero: computed from the registered f for every op.
- States: IDLE, BUSY. out_valid is a separate register; there is no DONE state.

Decomposition:
- Package alu_pkg holds: opcode localparams OP_ADD..OP_MUL (3-bit) and the state enum {IDLE, BUSY}.
- One sub-module: alu_mul_iter, a shift-add multiplier with start/done, WIDTH-cycle count, and 2*WIDTH product output.
- Combinational ops stay inline in alu_pipe.

Test Plan (WIDTH=32, MUL_EN=1 unless noted):
1. ADD x=1024 y=128; SUB x=8108 y=9375 -> f=1152 (all flags 0); then f=0xFFFFFB0D, cout=0, overflow=0. Each out_valid exactly 1 cycle after accept.
2. ADD x=0x7FFFFFFF y=1 -> f=0x80000000, overflow=1, cout=0. SUB x=5 y=5 -> f=0, zero=1, cout=1. SLT x=14507 y=97400 -> f=1. SLT x=0x7FFFFFFF y=0xFFFFFFFF -> f=0. SLT x=0x80000000 y=1 -> f=1.
3. SLL x=1 y=35 -> f=8. SRL x=0x80000000 y=31 -> f=1. SRL x=0x80000000 y=32 -> f=0x80000000.
4. MUL x=97400 y=14507 -> f=1412981800, overflow=0; out_valid 32 cycles after accept; in_ready=0 for those 32 cycles. MUL x=0x10000 y=0x10000 -> f=0, overflow=1, zero=1. With MUL_EN=0, opcode 7 -> f=0, illegal=1, latency 1.
5. Hold out_ready=0 for 5 cycles after an ADD result -> f and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (OR x=0xF0 y=0x0F) -> accepted that edge; next cycle out_valid=1, f=0xFF.
6. Assert reset on the 10th BUSY cycle of a MUL -> next cycle out_valid=0, zero=1, in_ready=1. A following ADD 2+3 -> f=5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and control state type for the
// pipelined ALU (alu_pipe, alu_mul_iter, alu_pipe_if).
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result bundle of alu_pipe.
// Upstream: in_valid/in_ready, x, y, opcode. Downstream: out_valid/out_ready, f + flags.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             illegal;

    modport slave (
        input  in_valid, x, y, opcode, out_ready,
        output in_ready, out_valid, f, cout, overflow, zero, illegal
    );

    modport master (
        output in_valid, x, y, opcode, out_ready,
        input  in_ready, out_valid, f, cout, overflow, zero, illegal
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per clock.
// Ports: clk, reset, start (loads a/b), done (pulse, final step), prod (2*WIDTH, valid with done).
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = 1'b0;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Last step: the owner registers prod on this same edge.
            if (cnt_q == CW'(WIDTH - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    // Combinational next accumulator so the result lands on the WIDTH-th edge.
    assign prod = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags; MUL is iterative.
// Ports: clk, reset (sync, active-high), bus (alu_pipe_if.slave: operands in, result out).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic               in_ready;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic               add_ovf;
    logic               sub_ovf;
    logic               slt;
    logic [SW-1:0]      shamt;

    logic [WIDTH-1:0]   res_f;
    logic               res_cout;
    logic               res_ovf;
    logic               res_ill;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign add_ext = {1'b0, bus.x} + {1'b0, bus.y};
    assign sub_ext = {1'b0, bus.x} + {1'b0, ~bus.y} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (bus.x[MSB] == bus.y[MSB]) && (add_ext[MSB] != bus.x[MSB]);
    assign sub_ovf = (bus.x[MSB] != bus.y[MSB]) && (sub_ext[MSB] != bus.x[MSB]);
    // True signed less-than: sign of x-y corrected by its overflow.
    assign slt     = sub_ext[MSB] ^ sub_ovf;
    assign shamt   = bus.y[SW-1:0];

    always_comb begin
        res_f    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        res_ill  = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                res_f    = add_ext[WIDTH-1:0];
                res_cout = add_ext[WIDTH];
                res_ovf  = add_ovf;
            end
            OP_OR:  res_f = bus.x | bus.y;
            OP_AND: res_f = bus.x & bus.y;
            OP_SUB: begin
                res_f    = sub_ext[WIDTH-1:0];
                res_cout = sub_ext[WIDTH];
                res_ovf  = sub_ovf;
            end
            OP_SLT: res_f = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL: res_f = bus.x << shamt;
            OP_SRL: res_f = bus.x >> shamt;
            // Only reaches the result path when the multiplier is disabled.
            default: res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        mul_start   = 1'b0;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (MUL_EN && (bus.opcode == OP_MUL)) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        f_d         = res_f;
                        cout_d      = res_cout;
                        ovf_d       = res_ovf;
                        ill_d       = res_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    f_d         = mul_prod[WIDTH-1:0];
                    cout_d      = 1'b0;
                    ovf_d       = |mul_prod[2*WIDTH-1:WIDTH];
                    ill_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (bus.x),
        .b     (bus.y),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = (f_q == '0);
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe (MUL_EN=1) plus a MUL_EN=0 instance.
// Vectors compare {out_valid, f, cout, overflow, zero, illegal}.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_pipe_if #(.WIDTH(32)) mif ();
    alu_pipe_if #(.WIDTH(32)) mif0 ();

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (mif0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] obs();
        return {mif.out_valid, mif.f, mif.cout, mif.overflow, mif.zero, mif.illegal};
    endfunction

    // Present one operation, step one edge, drop in_valid.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.opcode   = op;
        mif.x        = a;
        mif.y        = b;
        mif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (obs() !== {1'b1 ^ 1'b1, 32'd0, 4'b0010}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs(), {1'b0, 32'd0, 4'b0010});
        end
        total++;
        if (mif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", mif.in_ready);
        end
    endtask

    task automatic test_basic();
        send(OP_ADD, 32'd1024, 32'd128);
        total++;
        if (obs() !== {1'b1, 32'd1152, 4'b0000}) begin
            bad++;
            $display("FAIL add_basic got=%h want=%h", obs(), {1'b1, 32'd1152, 4'b0000});
        end
        send(OP_SUB, 32'd8108, 32'd9375);
        total++;
        if (obs() !== {1'b1, 32'hFFFFFB0D, 4'b0000}) begin
            bad++;
            $display("FAIL sub_b2b got=%h want=%h", obs(), {1'b1, 32'hFFFFFB0D, 4'b0000});
        end
        @(posedge clk);
        #1;
        total++;
        if (mif.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_one_cycle got=%b want=0", mif.out_valid);
        end
    endtask

    task automatic test_flags();
        logic [2:0]  ops [7];
        logic [31:0] xs  [7];
        logic [31:0] ys  [7];
        logic [36:0] ex  [7];
        ops[0] = OP_ADD; xs[0] = 32'h7FFFFFFF; ys[0] = 32'd1;
        ex[0]  = {1'b1, 32'h80000000, 4'b0100};
        ops[1] = OP_SUB; xs[1] = 32'd5; ys[1] = 32'd5;
        ex[1]  = {1'b1, 32'd0, 4'b1010};
        ops[2] = OP_SLT; xs[2] = 32'd14507; ys[2] = 32'd97400;
        ex[2]  = {1'b1, 32'd1, 4'b0000};
        ops[3] = OP_SLT; xs[3] = 32'h7FFFFFFF; ys[3] = 32'hFFFFFFFF;
        ex[3]  = {1'b1, 32'd0, 4'b0010};
        ops[4] = OP_SLT; xs[4] = 32'h80000000; ys[4] = 32'd1;
        ex[4]  = {1'b1, 32'd1, 4'b0000};
        ops[5] = OP_ADD; xs[5] = 32'hFFFFFFFF; ys[5] = 32'd1;
        ex[5]  = {1'b1, 32'd0, 4'b1010};
        ops[6] = OP_AND; xs[6] = 32'h0000F0F0; ys[6] = 32'h0000FF00;
        ex[6]  = {1'b1, 32'h0000F000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            send(ops[i], xs[i], ys[i]);
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL flags_%0d got=%h want=%h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_shift();
        send(OP_SLL, 32'd1, 32'd35);
        total++;
        if (obs() !== {1'b1, 32'd8, 4'b0000}) begin
            bad++;
            $display("FAIL sll_35 got=%h want=%h", obs(), {1'b1, 32'd8, 4'b0000});
        end
        send(OP_SRL, 32'h80000000, 32'd31);
        total++;
        if (obs() !== {1'b1, 32'd1, 4'b0000}) begin
            bad++;
            $display("FAIL srl_31 got=%h want=%h", obs(), {1'b1, 32'd1, 4'b0000});
        end
        send(OP_SRL, 32'h80000000, 32'd32);
        total++;
        if (obs() !== {1'b1, 32'h80000000, 4'b0000}) begin
            bad++;
            $display("FAIL srl_32 got=%h want=%h", obs(), {1'b1, 32'h80000000, 4'b0000});
        end
    endtask

    task automatic test_mul();
        int   cyc;
        logic rdy;
        send(OP_MUL, 32'd97400, 32'd14507);
        cyc = 0;
        rdy = 1'b0;
        while (!mif.out_valid && cyc < 40) begin
            if (mif.in_ready) rdy = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc !== 32) begin
            bad++;
            $display("FAIL mul_latency got=%0d want=32", cyc);
        end
        total++;
        if (rdy !== 1'b0) begin
            bad++;
            $display("FAIL mul_in_ready_busy got=%b want=0", rdy);
        end
        total++;
        if (obs() !== {1'b1, 32'd1412981800, 4'b0000}) begin
            bad++;
            $display("FAIL mul_small got=%h want=%h", obs(), {1'b1, 32'd1412981800, 4'b0000});
        end
        send(OP_MUL, 32'h00010000, 32'h00010000);
        cyc = 0;
        while (!mif.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc !== 32) begin
            bad++;
            $display("FAIL mul2_latency got=%0d want=32", cyc);
        end
        total++;
        if (obs() !== {1'b1, 32'd0, 4'b0110}) begin
            bad++;
            $display("FAIL mul_ovf got=%h want=%h", obs(), {1'b1, 32'd0, 4'b0110});
        end
        mif0.opcode   = OP_MUL;
        mif0.x        = 32'd123;
        mif0.y        = 32'd456;
        mif0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        mif0.in_valid = 1'b0;
        total++;
        if ({mif0.out_valid, mif0.f, mif0.cout, mif0.overflow, mif0.zero, mif0.illegal}
                !== {1'b1, 32'd0, 4'b0011}) begin
            bad++;
            $display("FAIL mul_disabled got=%b_%h_%b%b%b%b want=1_00000000_0011",
                mif0.out_valid, mif0.f, mif0.cout, mif0.overflow, mif0.zero, mif0.illegal);
        end
    endtask

    task automatic test_hold();
        mif.out_ready = 1'b0;
        send(OP_ADD, 32'd100, 32'd200);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({mif.in_ready, obs()} !== {1'b0, 1'b1, 32'd300, 4'b0000}) begin
                bad++;
                $display("FAIL hold_%0d got=%b_%h want=0_%h", i, mif.in_ready, obs(),
                    {1'b1, 32'd300, 4'b0000});
            end
            @(posedge clk);
            #1;
        end
        mif.out_ready = 1'b1;
        mif.opcode    = OP_OR;
        mif.x         = 32'h000000F0;
        mif.y         = 32'h0000000F;
        mif.in_valid  = 1'b1;
        #1;
        total++;
        if (mif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release_ready got=%b want=1", mif.in_ready);
        end
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
        total++;
        if (obs() !== {1'b1, 32'h000000FF, 4'b0000}) begin
            bad++;
            $display("FAIL hold_replace got=%h want=%h", obs(), {1'b1, 32'h000000FF, 4'b0000});
        end
    endtask

    task automatic test_reset_mid_mul();
        logic stray;
        @(posedge clk);
        #1;
        send(OP_MUL, 32'd97400, 32'd14507);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({mif.out_valid, mif.zero, mif.in_ready} !== 3'b011) begin
            bad++;
            $display("FAIL reset_mid_mul got=%b want=011",
                {mif.out_valid, mif.zero, mif.in_ready});
        end
        stray = 1'b0;
        repeat (40) begin
            if (mif.out_valid) stray = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("FAIL abandoned_mul_output got=%b want=0", stray);
        end
        send(OP_ADD, 32'd2, 32'd3);
        total++;
        if (obs() !== {1'b1, 32'd5, 4'b0000}) begin
            bad++;
            $display("FAIL add_after_reset got=%h want=%h", obs(), {1'b1, 32'd5, 4'b0000});
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        mif.in_valid  = 1'b0;
        mif.x         = '0;
        mif.y         = '0;
        mif.opcode    = OP_ADD;
        mif.out_ready = 1'b1;
        mif0.in_valid  = 1'b0;
        mif0.x         = '0;
        mif0.y         = '0;
        mif0.opcode    = OP_ADD;
        mif0.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_flags();
        test_shift();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
